// File: rtl/edge_bit_sampler.sv
// rtl/edge_bit_sampler.sv - oversampling bit counter with 3-point majority sampler
//
// Counts clk cycles within each bit period (edge_count) and bit periods
// within a frame (bit_count). It also takes three samples of RX_IN around
// mid-bit and majority-votes them into sampled_bit.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   RX_IN        serial line, already synchronous to clk
//   prescale     clk cycles per bit; values below 4 are treated as 4
//   cnt_en       counter enable; low clears counters and loads prescale
//   samp_en      sampling enable
//   edge_count   position within the current bit, 1..prescale_q (0 idle)
//   bit_count    bit index within the frame, 0..FRAME_BITS-1
//   sampled_bit  majority-voted value of the last sampled bit
//   sample_done  one-cycle pulse when sampled_bit has just been updated

module edge_bit_sampler #(
  parameter int FRAME_BITS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX_IN,
  input  logic [4:0] prescale,
  input  logic       cnt_en,
  input  logic       samp_en,
  output logic [4:0] edge_count,
  output logic [3:0] bit_count,
  output logic       sampled_bit,
  output logic       sample_done
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic [4:0] prescale_q;
  logic       s1;
  logic       s2;
  logic [4:0] pt1;
  logic [4:0] pt2;
  logic [4:0] pt3;
  logic       vote;

  // Sample points are centred on the middle of the bit. Because prescale_q
  // is at least 4, pt1 is at least 1 and pt3 is always below prescale_q.
  assign pt2  = prescale_q >> 1;
  assign pt1  = pt2 - 5'd1;
  assign pt3  = pt2 + 5'd1;
  assign vote = (s1 & s2) | (s1 & RX_IN) | (s2 & RX_IN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale_q  <= 5'd8;
      edge_count  <= 5'd0;
      bit_count   <= 4'd0;
      sampled_bit <= 1'b1;
      sample_done <= 1'b0;
      s1          <= 1'b0;
      s2          <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      if (!cnt_en) begin
        // Idle or abort: counters and partial samples clear, and sampled_bit
        // keeps its last value. The ratio is reloaded only while idle.
        prescale_q <= (prescale < 5'd4) ? 5'd4 : prescale;
        edge_count <= 5'd0;
        bit_count  <= 4'd0;
        s1         <= 1'b0;
        s2         <= 1'b0;
      end else begin
        if (edge_count == prescale_q) begin
          edge_count <= 5'd1;
          bit_count  <= (bit_count == LAST_BIT) ? 4'd0 : bit_count + 4'd1;
        end else begin
          edge_count <= edge_count + 5'd1;
        end
        if (samp_en) begin
          if (edge_count == pt1) begin
            s1 <= RX_IN;
          end
          if (edge_count == pt2) begin
            s2 <= RX_IN;
          end
          // The third sample is RX_IN itself and is used directly in the vote.
          if (edge_count == pt3) begin
            sampled_bit <= vote;
            sample_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule
